// File: rtl/decoder_rr_arbiter_if.sv
// Requester <-> arbiter bundle for decoder_rr_arbiter.
//   req       : one request bit per requester, held for the whole tenure
//   grant_en  : decoder enable, high while a requester owns the resource
//   grant_idx : decoder select (owner index), holds its last value when idle
//   grant_oh  : one-hot grant, decode(grant_idx) gated by grant_en
//   preempt   : one-cycle pulse when a tenure is forcibly ended
// master = requester side, slave = arbiter side.
interface decoder_rr_arbiter_if;
  logic [3:0] req;
  logic       grant_en;
  logic [1:0] grant_idx;
  logic [3:0] grant_oh;
  logic       preempt;

  modport master (output req, input  grant_en, grant_idx, grant_oh, preempt);
  modport slave  (input  req, output grant_en, grant_idx, grant_oh, preempt);
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for one 2-to-4 decoded resource shared by four requesters.
// Produces a registered select/enable pair for the decoder plus the matching
// one-hot grant. An owner keeps the grant while its req stays high; on release
// the grant is handed to the next requester in round-robin order at the same
// edge (no idle gap).
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : decoder_rr_arbiter_if.slave (req in; grant_en/idx/oh, preempt out)
//
// Build option: define ARB_TIMEOUT_EN to let an owner be preempted once it has
// held for MAX_HOLD cycles while someone else waits. Without it, preempt is 0.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  decoder_rr_arbiter_if.slave  bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (CNT_W < 31 && (1 << CNT_W) <= MAX_HOLD)) begin : g_bad_param
    $error("decoder_rr_arbiter: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] idx_q;
  logic       en_q;
  logic [3:0] oh_q;

  logic [3:0] others;
  logic [1:0] win;
  logic       take;
  logic       drop;

  // First requester at or after start, wrapping. Only consulted when r != 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] c;
    rr_pick = start;
    for (int i = 3; i >= 0; i--) begin
      c = start + 2'(i);
      if (r[c]) rr_pick = c;
    end
  endfunction

  // oh_q is zero in IDLE, so this is "every request except the owner's".
  // In GRANT last == idx_q, so searching from last+1 never re-picks the owner.
  assign others = bus.req & ~oh_q;
  assign win    = rr_pick(others, last + 2'd1);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             pre_q;
  logic             pre_n;
  logic             tmo;

  // >= rather than ==: an owner that ran past the limit with nobody waiting is
  // still preempted as soon as a competitor shows up.
  assign tmo = (hold_cnt >= CNT_W'(MAX_HOLD - 1));
`endif

  always_comb begin
    take = 1'b0;
    drop = 1'b0;
`ifdef ARB_TIMEOUT_EN
    pre_n = 1'b0;
`endif
    if (state == IDLE) begin
      take = |others;
    end else if (!bus.req[idx_q]) begin
      take = |others;
      drop = ~|others;
    end
`ifdef ARB_TIMEOUT_EN
    else if (tmo && |others) begin
      take  = 1'b1;
      pre_n = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 2'd3;
      idx_q <= 2'd0;
      en_q  <= 1'b0;
      oh_q  <= 4'd0;
    end else if (take) begin
      state <= GRANT;
      en_q  <= 1'b1;
      idx_q <= win;
      oh_q  <= 4'b0001 << win;
      last  <= win;
    end else if (drop) begin
      state <= IDLE;
      en_q  <= 1'b0;
      oh_q  <= 4'd0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      pre_q    <= 1'b0;
    end else begin
      pre_q <= pre_n;
      if (take)
        hold_cnt <= '0;
      else if (state == GRANT && hold_cnt != '1)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign bus.preempt = pre_q;
`else
  assign bus.preempt = 1'b0;
`endif

  assign bus.grant_en  = en_q;
  assign bus.grant_idx = idx_q;
  assign bus.grant_oh  = oh_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
module tb_decoder_rr_arbiter;
  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int owner;  // -1 when nobody owns the resource
    int last;   // last granted index
    int idx;    // value grant_idx should show
    int ten;    // completed cycles of the current tenure
    bit pre;
  } model_t;

  model_t m = '{owner: -1, last: 3, idx: 0, ten: 0, pre: 1'b0};

  function automatic int pick(logic [3:0] r, int from);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic model_t model_next(model_t s, logic [3:0] r);
    model_t     n;
    logic [3:0] obit;
    n = s;
    n.pre = 1'b0;
    if (s.owner < 0) begin
      if (r != 4'd0) begin
        n.owner = pick(r, s.last); n.last = n.owner; n.idx = n.owner; n.ten = 0;
      end
    end else if (!r[s.owner]) begin
      if (r != 4'd0) begin
        n.owner = pick(r, s.last); n.last = n.owner; n.idx = n.owner; n.ten = 0;
      end else begin
        n.owner = -1;
      end
    end else begin
      obit  = 4'(1) << s.owner;
      n.ten = s.ten + 1;
      if (TMO && n.ten >= MAX_HOLD && (r & ~obit) != 4'd0) begin
        n.owner = pick(r & ~obit, s.last); n.last = n.owner; n.idx = n.owner;
        n.ten = 0; n.pre = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '{owner: -1, last: 3, idx: 0, ten: 0, pre: 1'b0};
    else          m <= model_next(m, bus.req);
  end

  // Every-cycle scoreboard and one-hot invariant, sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0] got, exp;
    logic [3:0] eoh, dec;
    eoh = (m.owner >= 0) ? (4'(1) << m.owner) : 4'd0;
    exp = {(m.owner >= 0), 2'(m.idx), eoh, m.pre};
    got = {bus.grant_en, bus.grant_idx, bus.grant_oh, bus.preempt};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL model t=%0t {en,idx,oh,pre} got=%b expected=%b", $time, got, exp);
    end
    dec = bus.grant_en ? (4'(1) << bus.grant_idx) : 4'd0;
    checks++;
    if (bus.grant_oh !== dec) begin
      failures++;
      $display("FAIL onehot t=%0t grant_oh got=%b expected=%b", $time, bus.grant_oh, dec);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.grant_en, bus.grant_idx, bus.grant_oh, bus.preempt} !== 8'd0) begin
      failures++;
      $display("FAIL reset_state got=%b expected=%b",
               {bus.grant_en, bus.grant_idx, bus.grant_oh, bus.preempt}, 8'd0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.grant_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req grant_en got=%b expected=0", bus.grant_en);
    end
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.grant_en, bus.grant_idx, bus.grant_oh} !== {1'b1, 2'd2, 4'b0100}) begin
        failures++;
        $display("FAIL single_hold cyc%0d got en=%b idx=%0d oh=%b expected en=1 idx=2 oh=0100",
                 i, bus.grant_en, bus.grant_idx, bus.grant_oh);
      end
      if (i == 4) bus.req = 4'd0;
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.grant_en, bus.grant_idx, bus.grant_oh} !== {1'b0, 2'd2, 4'd0}) begin
      failures++;
      $display("FAIL single_release got en=%b idx=%0d oh=%b expected en=0 idx=2 oh=0000",
               bus.grant_en, bus.grant_idx, bus.grant_oh);
    end
  endtask

  task automatic test_rr();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n, prev, ten;
    do_reset();
    bus.req = 4'hF;
    n = 0; prev = -1; ten = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.grant_en !== 1'b1) begin
        failures++;
        $display("FAIL rr_no_gap cyc%0d grant_en got=%b expected=1", c, bus.grant_en);
      end
      if (int'(bus.grant_idx) != prev) begin
        checks++;
        if (int'(bus.grant_idx) != exp_order[n]) begin
          failures++;
          $display("FAIL rr_order #%0d grant_idx got=%0d expected=%0d", n, bus.grant_idx, exp_order[n]);
        end
        n++; prev = int'(bus.grant_idx); ten = 1;
      end else begin
        ten++;
      end
      bus.req = (ten == 2) ? (4'hF & ~(4'(1) << prev)) : 4'hF;
    end
    checks++;
    if (n < 5) begin
      failures++;
      $display("FAIL rr_budget owners seen got=%0d expected=5", n);
    end
    bus.req = 4'd0;
  endtask

  task automatic test_wrap();
    logic [3:0] reqs [7] = '{4'b1000, 4'b0011, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 4'b0011};
    logic [2:0] exps [7] = '{3'b1_11, 3'b1_00, 3'b1_01, 3'b0_01, 3'b1_01, 3'b1_00, 3'b1_00};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.req = reqs[i];
      @(posedge clk); #1;
      checks++;
      if ({bus.grant_en, bus.grant_idx} !== exps[i]) begin
        failures++;
        $display("FAIL wrap step%0d {en,idx} got=%b expected=%b", i, {bus.grant_en, bus.grant_idx}, exps[i]);
      end
    end
    bus.req = 4'd0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 10; i++) begin
      logic [3:0] exp;
      @(posedge clk); #1;
      exp = (i < 8) ? 4'b1_00_0 : (i == 8) ? 4'b1_01_1 : 4'b1_01_0;
      checks++;
      if ({bus.grant_en, bus.grant_idx, bus.preempt} !== exp) begin
        failures++;
        $display("FAIL timeout_preempt cyc%0d {en,idx,pre} got=%b expected=%b",
                 i, {bus.grant_en, bus.grant_idx, bus.preempt}, exp);
      end
    end
    do_reset();
    bus.req = 4'b0001;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.grant_en, bus.grant_idx, bus.preempt} !== 4'b1_00_0) begin
        failures++;
        $display("FAIL timeout_alone cyc%0d {en,idx,pre} got=%b expected=1000",
                 i, {bus.grant_en, bus.grant_idx, bus.preempt});
      end
    end
`else
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.grant_en, bus.grant_idx, bus.preempt} !== 4'b1_00_0) begin
        failures++;
        $display("FAIL no_timeout_hold cyc%0d {en,idx,pre} got=%b expected=1000",
                 i, {bus.grant_en, bus.grant_idx, bus.preempt});
      end
    end
    bus.req = 4'b0010;
    @(posedge clk); #1;
    checks++;
    if ({bus.grant_en, bus.grant_idx, bus.preempt} !== 4'b1_01_0) begin
      failures++;
      $display("FAIL no_timeout_handover {en,idx,pre} got=%b expected=1010",
               {bus.grant_en, bus.grant_idx, bus.preempt});
    end
`endif
    bus.req = 4'd0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b0100;
    @(posedge clk); #1;
    checks++;
    if (bus.grant_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_setup grant_en got=%b expected=1", bus.grant_en);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.grant_en, bus.grant_idx, bus.grant_oh, bus.preempt} !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b expected=%b",
               {bus.grant_en, bus.grant_idx, bus.grant_oh, bus.preempt}, 8'd0);
    end
    bus.req = 4'd0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    bus.req = 4'($urandom_range(0, 15));
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) bus.req = bus.req ^ (4'(1) << $urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) bus.req = 4'($urandom_range(0, 15));
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        #4 reset_n = 1'b1;
      end
    end
    bus.req = 4'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.req = 4'd0;
    test_reset();
    test_single();
    test_rr();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
